// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: PC-source selects,
// FSM states, the "no exception" vector and the EX/MEM bubble control word.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned VEC_W = 5;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_VECTOR = 2'd2,
    PC_EPC    = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_EXC_JUMP = 2'd2
  } state_e;

  localparam logic [VEC_W-1:0] VEC_NONE = 5'd0;

  // Control word EX/MEM loads when ex_flush turns its slot into a bubble.
  localparam logic [7:0] EXMEM_BUBBLE = 8'd1;

  // Exception vector table: one word per cause above the base.
  function automatic logic [XLEN-1:0] vector_target(input logic [XLEN-1:0] base,
                                                    input logic [VEC_W-1:0] c);
    return base + XLEN'({c, 2'b00});
  endfunction

endpackage

// File: rtl/pipe_div_timer.sv
// Divide occupancy timer: loads on start, counts down while the divider holds
// EX, flags the final stall cycle and clears when the divide is aborted.
module pipe_div_timer #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic abort,
  output logic last_c
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // The start cycle is the first EX cycle, so the last stall is when one remains.
  assign last_c = active && (count == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD;
    end else if (abort) begin
      count <= '0;
    end else if (active && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush/PC-select for load-use, branch,
// divide, exception entry and ERET. Optional counters under PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned     DIV_CYCLES = 32,
  parameter logic [XLEN-1:0] EXC_BASE   = 32'h0000_0080
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_div_start,
  input  logic             id_eret,
  input  logic [VEC_W-1:0] mem_vector,
  input  logic [XLEN-1:0]  mem_pc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_flush,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  exc_pc,
  output logic [XLEN-1:0]  epc,
  output logic [VEC_W-1:0] cause,
  output logic             div_done,
  output logic             div_abort
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  state_e state;
  state_e state_nxt;

  logic exc;
  logic load_use;
  logic div_start;
  logic div_kill;
  logic div_last_c;
  logic exc_take;

  assign exc      = (mem_vector != VEC_NONE);
  assign load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Vector is only honoured where EX/MEM holds a live instruction.
  assign exc_take  = reset && exc && ((state == ST_RUN) || (state == ST_DIV_WAIT));
  assign div_start = reset && (state == ST_RUN) && !exc && ex_div_start;
  assign div_kill  = reset && (state == ST_DIV_WAIT) && exc;

  pipe_div_timer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (div_start),
    .active (state == ST_DIV_WAIT),
    .abort  (div_kill),
    .last_c (div_last_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and same-cycle pipeline controls.
  always_comb begin
    state_nxt   = state;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_flush    = 1'b0;
    pc_sel      = PC_SEQ;
    div_done    = 1'b0;
    div_abort   = 1'b0;

    case (state)
      ST_RUN: begin
        if (exc) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_flush    = 1'b1;
          state_nxt   = ST_EXC_JUMP;
        end else if (ex_div_start) begin
          state_nxt = ST_DIV_WAIT;
        end else if (ex_branch_taken) begin
          // Squashing ID also removes any load-use hazard it carried.
          pc_sel      = PC_BRANCH;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_eret) begin
          pc_sel      = PC_EPC;
          if_id_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      ST_DIV_WAIT: begin
        if (exc) begin
          div_abort   = 1'b1;
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_flush    = 1'b1;
          state_nxt   = ST_EXC_JUMP;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          ex_flush    = 1'b1;
          if (div_last_c) begin
            div_done  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end

      ST_EXC_JUMP: begin
        pc_sel      = PC_VECTOR;
        pc_write    = 1'b1;
        if_id_flush = 1'b1;
        state_nxt   = ST_RUN;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    // Held reset freezes every pipeline register as a bubble.
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_flush    = 1'b1;
      pc_sel      = PC_SEQ;
      div_done    = 1'b0;
      div_abort   = 1'b0;
      state_nxt   = ST_RUN;
    end
  end

  // Exception capture of faulting PC and cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc   <= '0;
      cause <= VEC_NONE;
    end else if (exc_take) begin
      epc   <= mem_pc;
      cause <= mem_vector;
    end
  end

  assign exc_pc = vector_target(EXC_BASE, cause);

`ifdef PIPE_CTRL_PERF_EN
  logic flush_evt;

  // Only branch and exception flushes count; load-use and divide bubbles do not.
  assign flush_evt = exc_take ||
                     (reset && (state == ST_RUN) && !ex_div_start && ex_branch_taken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_evt) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (DIV_CYCLES=4): directed vectors push
// expected controls; a monitor compares them against the DUT each cycle.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt, mem_vector;
  logic        ex_memread, ex_branch_taken, ex_div_start, id_eret;
  logic [31:0] mem_pc;
  logic        pc_write, if_id_write, id_ex_write;
  logic        if_id_flush, id_ex_flush, ex_flush;
  logic [1:0]  pc_sel;
  logic [31:0] exc_pc, epc;
  logic [4:0]  cause;
  logic        div_done, div_abort;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .DIV_CYCLES (4),
    .EXC_BASE   (32'h0000_0080)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_div_start    (ex_div_start),
    .id_eret         (id_eret),
    .mem_vector      (mem_vector),
    .mem_pc          (mem_pc),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_flush        (ex_flush),
    .pc_sel          (pc_sel),
    .exc_pc          (exc_pc),
    .epc             (epc),
    .cause           (cause),
    .div_done        (div_done),
    .div_abort       (div_abort)
  );

  // {pc_write,if_id_write,id_ex_write, if_id_flush,id_ex_flush,ex_flush, pc_sel, div_done,div_abort}
  localparam logic [9:0] C_RUN   = 10'b111_000_00_00;
  localparam logic [9:0] C_RST   = 10'b000_111_00_00;
  localparam logic [9:0] C_LU    = 10'b001_010_00_00;
  localparam logic [9:0] C_BR    = 10'b111_110_01_00;
  localparam logic [9:0] C_ERET  = 10'b111_100_11_00;
  localparam logic [9:0] C_EXC   = 10'b011_111_00_00;
  localparam logic [9:0] C_JUMP  = 10'b111_100_10_00;
  localparam logic [9:0] C_DIV   = 10'b000_001_00_00;
  localparam logic [9:0] C_DONE  = 10'b000_001_00_10;
  localparam logic [9:0] C_ABORT = 10'b011_111_00_01;

  typedef struct {
    logic [9:0]  ctrl;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;
  bit   stim_done = 1'b0;

  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic memread, input logic [4:0] exrt, input logic br,
                      input logic divs, input logic eret, input logic [4:0] vec,
                      input logic [31:0] pc, input logic [9:0] ctrl,
                      input logic [31:0] e_epc, input logic [4:0] e_cause);
    exp_t e;
    @(negedge clk);
    reset = rst; id_rs = rs; id_rt = rt; ex_memread = memread; ex_rt = exrt;
    ex_branch_taken = br; ex_div_start = divs; id_eret = eret;
    mem_vector = vec; mem_pc = pc;
    e.ctrl   = ctrl;
    e.epc    = e_epc;
    e.cause  = e_cause;
    e.exc_pc = 32'h0000_0080 + {25'd0, e_cause, 2'b00};
    e.id     = step_id;
    step_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    int          cycles;
    exp_t        e;
    logic [9:0]  act;
    cycles = 0;
    forever begin
      @(negedge clk);
      #1;
      cycles++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
               ex_flush, pc_sel, div_done, div_abort};
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl#%0d got %b want %b", e.id, act, e.ctrl);
        end
        checks++;
        if ({epc, cause, exc_pc} !== {e.epc, e.cause, e.exc_pc}) begin
          errors++;
          $display("FAIL regs#%0d got epc=%h cause=%0d exc_pc=%h want epc=%h cause=%0d exc_pc=%h",
                   e.id, epc, cause, exc_pc, e.epc, e.cause, e.exc_pc);
        end
      end else if (stim_done) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (cycles > 2000) begin
        errors++;
        checks++;
        $display("FAIL watchdog got %0d cycles want <= 2000", cycles);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    reset = 1'b0; id_rs = '0; id_rt = '0; ex_memread = 1'b0; ex_rt = '0;
    ex_branch_taken = 1'b0; ex_div_start = 1'b0; id_eret = 1'b0;
    mem_vector = '0; mem_pc = '0;
    //   rst rs rt mr exrt br dv er vec pc            ctrl     epc           cause
    step(0,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RST,   32'h0,        5'd0);
    step(0,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RST,   32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h0,        5'd0);
    // Load-use on rs, release, ex_rt=0 boundary, load-use on rt
    step(1,  8, 0, 1, 8,   0, 0, 0, 0,  32'h0,       C_LU,    32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h0,        5'd0);
    step(1,  0, 0, 1, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h0,        5'd0);
    step(1,  1, 5, 1, 5,   0, 0, 0, 0,  32'h0,       C_LU,    32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h0,        5'd0);
    // Branch with a hazard; ERET alone
    step(1,  8, 0, 1, 8,   1, 0, 0, 0,  32'h0,       C_BR,    32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 1, 0,  32'h0,       C_ERET,  32'h0,        5'd0);
    // Exception beats branch; vector in EXC_JUMP ignored; ERET sees epc
    step(1,  0, 0, 0, 0,   1, 0, 0, 3,  32'h40,      C_EXC,   32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 7,  32'h99,      C_JUMP,  32'h40,       5'd3);
    step(1,  0, 0, 0, 0,   0, 0, 1, 0,  32'h0,       C_ERET,  32'h40,       5'd3);
    // Divide beats branch; 3 stalls, done on the third
    step(1,  0, 0, 0, 0,   1, 1, 0, 0,  32'h0,       C_RUN,   32'h40,       5'd3);
    step(1,  8, 0, 1, 8,   1, 0, 0, 0,  32'h0,       C_DIV,   32'h40,       5'd3);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_DIV,   32'h40,       5'd3);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_DONE,  32'h40,       5'd3);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h40,       5'd3);
    // Divide aborted by exception on the second stall cycle
    step(1,  0, 0, 0, 0,   0, 1, 0, 0,  32'h0,       C_RUN,   32'h40,       5'd3);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_DIV,   32'h40,       5'd3);
    step(1,  0, 0, 0, 0,   0, 0, 0, 5,  32'h100,     C_ABORT, 32'h40,       5'd3);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_JUMP,  32'h100,      5'd5);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h100,      5'd5);
    // Async reset mid DIV_WAIT, then a full divide afterwards
    step(1,  0, 0, 0, 0,   0, 1, 0, 0,  32'h0,       C_RUN,   32'h100,      5'd5);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_DIV,   32'h100,      5'd5);
    step(0,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RST,   32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 1, 0, 0,  32'h0,       C_RUN,   32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_DIV,   32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_DIV,   32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_DONE,  32'h0,        5'd0);
    step(1,  0, 0, 0, 0,   0, 0, 0, 0,  32'h0,       C_RUN,   32'h0,        5'd0);
    stim_done = 1'b1;
  end

endmodule
